// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: takes one read or write command, runs it on the
// AXI channels and returns one response, aborting with SLVERR if the slave stalls too long.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for a command, cmd_ready high
// WR_REQ  | AW and W valids out, each drops on its own handshake
// WR_RESP | bready high, waiting for the write response
// RD_REQ  | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for read data
// RSP     | rsp_valid high and stable until rsp_ready
module axi_lite_master #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,

   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,

   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,

   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,

   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,

   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,

   output logic                    busy
);

   localparam int STRB_W = DATA_WIDTH / 8;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;
   localparam logic [2:0] RSP     = 3'd5;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic [2:0]              state_q,   state_d;
   logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [STRB_W-1:0]       wstrb_q,   wstrb_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q,  wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
   logic [1:0]              resp_q,    resp_d;
   logic                    tmo_q,     tmo_d;
   logic [15:0]             wait_q,    wait_d;

   logic aw_done;
   logic w_done;
   logic tmo_hit;

   assign aw_done = !awvalid_q || m_axi_awready;
   assign w_done  = !wvalid_q  || m_axi_wready;
   // >= rather than == so a phase entered after a last-cycle handshake still times out
   assign tmo_hit = (wait_q >= TMO_LAST);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      tmo_d     = tmo_q;
      wait_d    = wait_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               wait_d  = 16'd0;
               rdata_d = '0;
               resp_d  = 2'b00;
               tmo_d   = 1'b0;
               if (cmd_write) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end

         WR_REQ: begin
            wait_d    = wait_q + 16'd1;
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q && !m_axi_wready;
            if (aw_done && w_done) begin
               state_d = WR_RESP;
            end else if (tmo_hit) begin
               state_d   = RSP;
               awvalid_d = 1'b0;
               wvalid_d  = 1'b0;
               resp_d    = RESP_SLVERR;
               tmo_d     = 1'b1;
               rdata_d   = '0;
            end
         end

         WR_RESP: begin
            wait_d = wait_q + 16'd1;
            if (m_axi_bvalid) begin
               resp_d  = m_axi_bresp;
               state_d = RSP;
            end else if (tmo_hit) begin
               state_d = RSP;
               resp_d  = RESP_SLVERR;
               tmo_d   = 1'b1;
               rdata_d = '0;
            end
         end

         RD_REQ: begin
            wait_d = wait_q + 16'd1;
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_DATA;
            end else if (tmo_hit) begin
               arvalid_d = 1'b0;
               state_d   = RSP;
               resp_d    = RESP_SLVERR;
               tmo_d     = 1'b1;
               rdata_d   = '0;
            end
         end

         RD_DATA: begin
            wait_d = wait_q + 16'd1;
            if (m_axi_rvalid) begin
               rdata_d = m_axi_rdata;
               resp_d  = m_axi_rresp;
               state_d = RSP;
            end else if (tmo_hit) begin
               state_d = RSP;
               resp_d  = RESP_SLVERR;
               tmo_d   = 1'b1;
               rdata_d = '0;
            end
         end

         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         tmo_q     <= 1'b0;
         wait_q    <= 16'd0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         tmo_q     <= tmo_d;
         wait_q    <= wait_d;
      end
   end

   // Gated by rst so no command can slip in while reset is still asserted
   assign cmd_ready     = (state_q == IDLE) && !rst;
   assign busy          = (state_q != IDLE);

   assign rsp_valid     = (state_q == RSP);
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign rsp_timeout   = tmo_q;

   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = (state_q == WR_RESP);
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = (state_q == RD_DATA);

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the AXI/command address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width; legal values are 32 and 64.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, the maximum wait cycles per transaction; legal values are 2 to 65535.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  ADDR_WIDTH  target address.
REQ-009 cmd_wdata / cmd_wstrb  input  DATA_WIDTH / DATA_WIDTH/8  write data and byte strobes.
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-012 rsp_resp  output  2  AXI response code.
REQ-013 rsp_timeout  output  1  transaction aborted by timeout.
REQ-014 m_axi_aw{valid,ready,addr,prot}  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel.
REQ-015 m_axi_w{valid,ready,data,strb}  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel.
REQ-016 m_axi_b{valid,ready,resp}  in/out/in  1/1/2  write response channel.
REQ-017 m_axi_ar{valid,ready,addr,prot}  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel.
REQ-018 m_axi_r{valid,ready,data,resp}  in/out/in/in  1/1/DATA_WIDTH/2  read data channel.
REQ-019 busy  output  1  state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, and RSP.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&&cmd_ready and its fields are registered.
REQ-022 On an accepted write, the next state SHALL be WR_REQ with awvalid=1 and wvalid=1 in the following cycle.
REQ-023 In WR_REQ, awvalid and wvalid SHALL each drop independently after their own handshake; the FSM leaves WR_REQ when both handshakes are done, whether in the same cycle or in different cycles.
REQ-024 In WR_RESP, bready SHALL be 1; on bvalid, bresp is captured into rsp_resp and the next state is RSP.
REQ-025 On an accepted read, the next state SHALL be RD_REQ with arvalid=1; on arready the next state is RD_DATA.
REQ-026 In RD_DATA, rready SHALL be 1; on rvalid, rdata and rresp are captured and the next state is RSP.
REQ-027 In RSP, rsp_valid SHALL be 1 and held stable until rsp_ready, then the next state is IDLE; a new command is not accepted in the same cycle.
REQ-028 Each valid SHALL stay asserted, with address/data/strb stable, until its handshake; a valid never depends combinationally on its ready.
REQ-029 awaddr, araddr, wdata and wstrb SHALL be registered outputs; awprot and arprot are constant 3'b000.
REQ-030 A 16-bit wait counter SHALL clear on command accept and increment each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-031 When the wait counter equals TIMEOUT_CYCLES-1 with no completing handshake in that cycle, the block SHALL drop all m_axi valids/readies and go to RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
REQ-032 A completing handshake in the same cycle as the timeout condition SHALL take priority over the timeout.
REQ-033 Best-case latency from cmd accept to rsp_valid SHALL be 3 cycles when ready and b/r valid are constant 1 (write: accept, AW/W, B, RSP; read: accept, AR, R, RSP).
REQ-034 rsp_timeout SHALL be 0 for every non-timeout response.

Reset
REQ-035 When rst=1 on a clock edge, the state SHALL become IDLE and every m_axi valid/ready, rsp_valid, rsp_timeout, busy, and the wait counter SHALL become 0.
REQ-036 Under reset, cmd_ready SHALL be 0 while rst=1 and become 1 in the first cycle after rst falls.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no response generated.
REQ-038 Under reset, rsp_rdata, rsp_resp, and the registered addr/data/strb SHALL become 0.

Verification
REQ-039 Write 0x0000_00A5 to 0x10 with wstrb=0xF, slave always ready, bresp=00 -> one AW and one W handshake, rsp_resp=00, rsp_valid 3 cycles after accept.
REQ-040 Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid is held 5 cycles, exactly one B is accepted.
REQ-041 Read 0x04 with slave returning 0xDEAD_BEEF and rresp=00 after 2 wait cycles -> rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_timeout=0.
REQ-042 Read with arready held 0 and TIMEOUT_CYCLES=8 -> arvalid drops 8 cycles after first assertion; rsp_resp=10, rsp_timeout=1.
REQ-043 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_* stable for 5 cycles, cmd_ready=0 throughout.
REQ-044 rst pulsed during WR_RESP -> all valids 0 next cycle, no rsp_valid, the next command completes normally.
